// File: rtl/axis_pixel_packer_pkg.sv
// Shared types for the greyscale-to-RGB888 AXI4-Stream pixel packer.
// Word layout, FSM states and the default shade width live here.
`ifndef COLOR_WIDTH
`define COLOR_WIDTH 8
`endif

package axis_pixel_packer_pkg;

    localparam int COLOR_WIDTH = `COLOR_WIDTH;

    typedef struct packed {
        logic [31:0] tdata;
        logic        tuser;
        logic        tlast;
    } word_t;

    localparam int WORD_BITS = $bits(word_t);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Generic 2-entry FIFO with a registered occupancy count.
// The head entry drives the outputs directly, so read data is always a flop output.
module axis_skid_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop;
    logic             do_push;

    assign pop     = (count != 2'd0) && pop_ready;
    assign do_push = push && ((count != 2'd2) || pop);

    // NOTE: the two storage entries are reset as well; tail is kept at zero whenever
    // fewer than two words are held, which guarantees data reads zero when empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({do_push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               tail <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    tail  <= '0;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data  = head;
    assign valid = (count != 2'd0);

endmodule

// File: rtl/axis_pixel_packer.sv
// Expands greyscale shades to RGB888 and packs 4 pixels into 3 little-endian
// 32-bit AXI4-Stream words (tuser = start of frame, tlast = end of line).
module axis_pixel_packer #(
    parameter int COLOR_WIDTH = axis_pixel_packer_pkg::COLOR_WIDTH,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COLOR_WIDTH-1:0] s_shade,
    input  logic                   s_valid,
    input  logic                   s_sof,
    input  logic                   s_eol,
    output logic                   s_ready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tlast,
    output logic                   sync_err
);

    import axis_pixel_packer_pkg::*;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("axis_pixel_packer: DATA_WIDTH must be 32");
    end

    logic [7:0] grey;

    if (COLOR_WIDTH > 8) begin : g_trunc
        assign grey = s_shade[COLOR_WIDTH-1 -: 8];
    end else begin : g_replicate
        // Left-align the shade and keep repeating its MSBs into the vacated LSBs.
        always_comb begin
            for (int i = 0; i < 8; i++) begin
                grey[7-i] = s_shade[COLOR_WIDTH-1-(i % COLOR_WIDTH)];
            end
        end
    end

    state_t      state, state_n;
    logic [1:0]  fill, fill_n, fill_eff;
    logic [23:0] residual, residual_n, residual_eff;
    logic        pending_sof, pending_sof_n;
    logic        sync_err_n;
    logic        push;
    word_t       push_word;
    word_t       fifo_word;
    logic [1:0]  fifo_count;

    assign s_ready = (state == RUN) && (fifo_count != 2'd2);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            fill        <= 2'd0;
            residual    <= '0;
            pending_sof <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            fill        <= fill_n;
            residual    <= residual_n;
            pending_sof <= pending_sof_n;
            sync_err    <= sync_err_n;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_n       = state;
        fill_n        = fill;
        residual_n    = residual;
        pending_sof_n = pending_sof;
        sync_err_n    = sync_err;
        fill_eff      = fill;
        residual_eff  = residual;
        push          = 1'b0;
        push_word     = '0;

        case (state)
            RUN: begin
                if (s_valid && s_ready) begin
                    // A new frame discards any half-built word from the old one.
                    if (s_sof) begin
                        fill_eff      = 2'd0;
                        residual_eff  = '0;
                        pending_sof_n = 1'b1;
                        if (fill != 2'd0) sync_err_n = 1'b1;
                    end

                    case (fill_eff)
                        2'd0: begin
                            residual_n = {grey, grey, grey};
                            fill_n     = 2'd3;
                        end
                        2'd3: begin
                            push            = 1'b1;
                            push_word.tdata = {grey, residual_eff};
                            residual_n      = {8'h00, grey, grey};
                            fill_n          = 2'd2;
                        end
                        2'd2: begin
                            push            = 1'b1;
                            push_word.tdata = {grey, grey, residual_eff[15:0]};
                            residual_n      = {16'h0000, grey};
                            fill_n          = 2'd1;
                        end
                        default: begin
                            push            = 1'b1;
                            push_word.tdata = {grey, grey, grey, residual_eff[7:0]};
                            residual_n      = '0;
                            fill_n          = 2'd0;
                        end
                    endcase

                    if (s_eol) begin
                        if (fill_n == 2'd0) push_word.tlast = 1'b1;
                        else                state_n         = FLUSH;
                    end

                    if (push) begin
                        push_word.tuser = pending_sof;
                        pending_sof_n   = 1'b0;
                    end
                end
            end

            FLUSH: begin
                if (fifo_count != 2'd2) begin
                    push            = 1'b1;
                    push_word.tdata = {8'h00, residual};
                    push_word.tuser = pending_sof;
                    push_word.tlast = 1'b1;
                    pending_sof_n   = 1'b0;
                    residual_n      = '0;
                    fill_n          = 2'd0;
                    state_n         = RUN;
                end
            end

            default: state_n = RUN;
        endcase
    end

    axis_skid_fifo2 #(
        .WIDTH(WORD_BITS)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_word),
        .pop_ready(m_axis_tready),
        .data     (fifo_word),
        .valid    (m_axis_tvalid),
        .count    (fifo_count)
    );

    assign m_axis_tdata = fifo_word.tdata;
    assign m_axis_tuser = fifo_word.tuser;
    assign m_axis_tlast = fifo_word.tlast;

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Directed bench for axis_pixel_packer: packing, flush, backpressure, SOF resync, reset.
`timescale 1ns/1ps
module tb_axis_pixel_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_shade;
    logic        s_valid, s_sof, s_eol, s_ready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic        sync_err;

    int n_checks = 0;
    int n_pass   = 0;
    int ready_low = 0;
    logic [33:0] got[$];

    always #5 clk = ~clk;

    axis_pixel_packer #(
        .COLOR_WIDTH(8),
        .DATA_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_shade      (s_shade),
        .s_valid      (s_valid),
        .s_sof        (s_sof),
        .s_eol        (s_eol),
        .s_ready      (s_ready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .sync_err     (sync_err)
    );

    // Records every popped word {tdata, tuser, tlast} and cycles with s_ready low.
    always @(negedge clk) begin
        if (rst) begin
            if (m_axis_tvalid && m_axis_tready)
                got.push_back({m_axis_tdata, m_axis_tuser, m_axis_tlast});
            if (!s_ready) ready_low++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] got_at(int i);
        return (i < got.size()) ? got[i] : 34'hx;
    endfunction

    function automatic logic [7:0] shade_of(int k);
        return 8'((k * 37 + 5) % 256);
    endfunction

    // Reference byte-stream model: pixel k contributes bytes 3k..3k+2.
    function automatic logic [31:0] exp_word(int j);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = shade_of((4 * j + b) / 3);
        return w;
    endfunction

    task automatic send_pixel(input logic [7:0] shade, input logic sof, input logic eol);
        logic acc = 1'b0;
        s_valid = 1'b1;
        s_shade = shade;
        s_sof   = sof;
        s_eol   = eol;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = s_ready;
            tick();
        end
        n_checks++;
        if (!acc) $display("FAIL send_timeout shade=%h accepted=0 required=1", shade);
        else      n_pass++;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_shade = 8'h00;
        m_axis_tready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got=%b required=0", m_axis_tvalid); else n_pass++;
        n_checks++; if (m_axis_tdata !== 32'h0) $display("FAIL reset_tdata got=%h required=0", m_axis_tdata); else n_pass++;
        n_checks++; if (m_axis_tuser !== 1'b0) $display("FAIL reset_tuser got=%b required=0", m_axis_tuser); else n_pass++;
        n_checks++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast got=%b required=0", m_axis_tlast); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got=%b required=1", s_ready); else n_pass++;
        n_checks++; if (sync_err !== 1'b0) $display("FAIL reset_sync_err got=%b required=0", sync_err); else n_pass++;
        tick();
    endtask

    task automatic test_line4();
        logic [33:0] exp[3] = '{{32'h20101010, 2'b10}, {32'h30302020, 2'b00}, {32'h40404030, 2'b01}};
        int rl0;
        got.delete();
        m_axis_tready = 1'b1;
        rl0 = ready_low;
        send_pixel(8'h10, 1'b1, 1'b0);
        send_pixel(8'h20, 1'b0, 1'b0);
        send_pixel(8'h30, 1'b0, 1'b0);
        send_pixel(8'h40, 1'b0, 1'b1);
        repeat (5) tick();
        n_checks++; if (got.size() != 3) $display("FAIL line4_count got=%0d required=3", got.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got_at(i) !== exp[i]) $display("FAIL line4_word%0d got=%h required=%h", i, got_at(i), exp[i]);
            else n_pass++;
        end
        n_checks++; if (ready_low - rl0 != 0) $display("FAIL line4_ready_low got=%0d required=0", ready_low - rl0); else n_pass++;
    endtask

    task automatic test_one_pixel();
        int rl0;
        got.delete();
        rl0 = ready_low;
        send_pixel(8'hAA, 1'b1, 1'b1);
        repeat (5) tick();
        n_checks++; if (got.size() != 1) $display("FAIL one_px_count got=%0d required=1", got.size()); else n_pass++;
        n_checks++;
        if (got_at(0) !== {32'h00AAAAAA, 2'b11}) $display("FAIL one_px_word got=%h required=%h", got_at(0), {32'h00AAAAAA, 2'b11});
        else n_pass++;
        n_checks++; if (ready_low - rl0 != 1) $display("FAIL one_px_flush_cycles got=%0d required=1", ready_low - rl0); else n_pass++;
    endtask

    task automatic test_two_pixel();
        logic [33:0] exp[2] = '{{32'h22111111, 2'b00}, {32'h00002222, 2'b01}};
        got.delete();
        send_pixel(8'h11, 1'b0, 1'b0);
        send_pixel(8'h22, 1'b0, 1'b1);
        repeat (5) tick();
        n_checks++; if (got.size() != 2) $display("FAIL two_px_count got=%0d required=2", got.size()); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_at(i) !== exp[i]) $display("FAIL two_px_word%0d got=%h required=%h", i, got_at(i), exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int k = 0, pushed = 0, popped = 0;
        logic stall = 1'b0;
        logic [33:0] held = '0;
        logic [33:0] obs, req;
        for (int cyc = 0; cyc < 5000 && popped < 480; cyc++) begin
            m_axis_tready = !(cyc >= 200 && cyc < 210) && (cyc % 3 != 2);
            if (k < 640) begin
                s_valid = 1'b1; s_shade = shade_of(k); s_sof = (k == 0); s_eol = (k == 639);
            end else begin
                s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
            end
            @(negedge clk);
            obs = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
            n_checks++;
            if (s_ready !== ((pushed - popped) < 2))
                $display("FAIL stream_s_ready cyc=%0d got=%b required=%b", cyc, s_ready, (pushed - popped) < 2);
            else n_pass++;
            n_checks++;
            if (m_axis_tvalid !== ((pushed - popped) > 0))
                $display("FAIL stream_tvalid cyc=%0d got=%b required=%b", cyc, m_axis_tvalid, (pushed - popped) > 0);
            else n_pass++;
            if (stall) begin
                n_checks++;
                if (m_axis_tvalid !== 1'b1 || obs !== held)
                    $display("FAIL stream_stable cyc=%0d got=%h required=%h", cyc, obs, held);
                else n_pass++;
            end
            stall = m_axis_tvalid && !m_axis_tready;
            held  = obs;
            if (m_axis_tvalid && m_axis_tready) begin
                req = {exp_word(popped), popped == 0, popped == 479};
                n_checks++;
                if (obs !== req) $display("FAIL stream_word%0d got=%h required=%h", popped, obs, req);
                else n_pass++;
                popped++;
            end
            if (s_valid && s_ready) begin
                if (k % 4 != 0) pushed++;
                k++;
            end
            tick();
        end
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
        m_axis_tready = 1'b1;
        n_checks++; if (popped != 480) $display("FAIL stream_word_count got=%0d required=480", popped); else n_pass++;
        n_checks++; if (k != 640) $display("FAIL stream_pixel_count got=%0d required=640", k); else n_pass++;
        repeat (5) tick();
        @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL stream_no_extra got=%b required=0", m_axis_tvalid); else n_pass++;
        tick();
    endtask

    task automatic test_sync_err();
        got.delete();
        send_pixel(8'h01, 1'b0, 1'b0);
        send_pixel(8'h99, 1'b1, 1'b1);
        repeat (5) tick();
        n_checks++; if (sync_err !== 1'b1) $display("FAIL sync_err_set got=%b required=1", sync_err); else n_pass++;
        n_checks++; if (got.size() != 1) $display("FAIL sync_count got=%0d required=1", got.size()); else n_pass++;
        n_checks++;
        if (got_at(0) !== {32'h00999999, 2'b11}) $display("FAIL sync_word got=%h required=%h", got_at(0), {32'h00999999, 2'b11});
        else n_pass++;
        send_pixel(8'h10, 1'b0, 1'b0);
        send_pixel(8'h20, 1'b0, 1'b0);
        send_pixel(8'h30, 1'b0, 1'b0);
        send_pixel(8'h40, 1'b0, 1'b1);
        repeat (5) tick();
        n_checks++; if (sync_err !== 1'b1) $display("FAIL sync_err_sticky got=%b required=1", sync_err); else n_pass++;
        n_checks++;
        if (got_at(1) !== {32'h20101010, 2'b00}) $display("FAIL sync_next_line got=%h required=%h", got_at(1), {32'h20101010, 2'b00});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [33:0] exp[3] = '{{32'h20101010, 2'b10}, {32'h30302020, 2'b00}, {32'h40404030, 2'b01}};
        got.delete();
        m_axis_tready = 1'b0;
        send_pixel(8'h50, 1'b0, 1'b0);
        send_pixel(8'h60, 1'b0, 1'b0);
        send_pixel(8'h70, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b0) $display("FAIL mid_full_s_ready got=%b required=0", s_ready); else n_pass++;
        n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL mid_full_tvalid got=%b required=1", m_axis_tvalid); else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL mid_tvalid got=%b required=0", m_axis_tvalid); else n_pass++;
        n_checks++; if (m_axis_tdata !== 32'h0) $display("FAIL mid_tdata got=%h required=0", m_axis_tdata); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL mid_s_ready got=%b required=1", s_ready); else n_pass++;
        n_checks++; if (sync_err !== 1'b0) $display("FAIL mid_sync_err got=%b required=0", sync_err); else n_pass++;
        tick();
        m_axis_tready = 1'b1;
        send_pixel(8'h10, 1'b1, 1'b0);
        send_pixel(8'h20, 1'b0, 1'b0);
        send_pixel(8'h30, 1'b0, 1'b0);
        send_pixel(8'h40, 1'b0, 1'b1);
        repeat (5) tick();
        n_checks++; if (got.size() != 3) $display("FAIL mid_count got=%0d required=3", got.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got_at(i) !== exp[i]) $display("FAIL mid_word%0d got=%h required=%h", i, got_at(i), exp[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_line4();
        test_one_pixel();
        test_two_pixel();
        test_back_to_back();
        test_sync_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_pixel_packer.md
Name: axis_pixel_packer

Overview:
Downstream of the ray-marcher pixel counter stage. Consumes one greyscale shade per handshake, with frame and line markers, expands it to RGB888 and packs 4 pixels into 3 32-bit words on an AXI4-Stream video master (tuser=SOF, tlast=EOL) for the VDMA. Provides the ready backpressure that the pixel counter stage honours.

Parameters:
COLOR_WIDTH, `COLOR_WIDTH, width of the incoming shade value.
DATA_WIDTH, 32, AXI-Stream tdata width. Fixed at 32; any other value is a compile-time error.

Ports:
clk  in  1  single clock, all logic rising-edge.
rst  in  1  reset: synchronous, active-low.
s_shade  in  COLOR_WIDTH  grey shade of the current pixel.
s_valid  in  1  s_shade, s_sof and s_eol are valid.
s_sof  in  1  first pixel of the frame.
s_eol  in  1  last pixel of the line.
s_ready  out  1  the block accepts a pixel this cycle.
m_axis_tdata  out  32  packed RGB888 bytes.
m_axis_tvalid  out  1  output word valid.
m_axis_tready  in  1  sink accepts the word.
m_axis_tuser  out  1  first word of the frame.
m_axis_tlast  out  1  last word of the line.
sync_err  out  1  sticky: SOF arrived with bytes still in the residual.

Behaviour:
- Handshakes: a pixel is accepted on a clock edge where s_valid&&s_ready. A word is popped on an edge where m_axis_tvalid&&m_axis_tready. After m_axis_tvalid rises, tdata, tuser and tlast stay stable until the word is popped.
- Grey expansion to 8 bits:
  - COLOR_WIDTH=8: use the shade unchanged.
  - COLOR_WIDTH<8: left-align and fill the LSBs with the replicated MSBs.
  - COLOR_WIDTH>8: take the top 8 bits.
  - Each pixel becomes 3 equal bytes g,g,g.
- Byte stream order: the first byte goes to tdata[7:0] (little-endian). Pad bytes are 0x00.
- Residual register: 24 bits plus a count r in {0,1,2,3}. Per accepted pixel:
  - r=0: no word; r becomes 3.
  - r=3: emit one word; r becomes 2.
  - r=2: emit one word; r becomes 1.
  - r=1: emit one word; r becomes 0.
- Output FIFO:
  - 2-entry FIFO holding {tdata, tuser, tlast}.
  - A word pushed at edge N is visible with tvalid=1 in cycle N+1 (1-cycle latency).
  - Simultaneous push and pop is allowed.
- s_ready = (state==RUN) && (fifo_count<2). It is derived from registers only, with no combinational path from m_axis_tready.
- Throughput: sustains 1 pixel/cycle while m_axis_tready is held high.
- State machine: RUN, FLUSH.
  - In RUN, accepting a pixel with s_eol:
    - If r becomes 0 after the pixel, the emitted word carries tlast=1 and the state stays RUN.
    - Otherwise the pixel's word (if any) is pushed with tlast=0 and the state goes to FLUSH.
  - In FLUSH, s_ready=0. On the first cycle with fifo_count<2:
    - Push the residual bytes zero-padded to 4 bytes, with tlast=1.
    - Set r=0 and return to RUN.
    - One push per cycle maximum.
- tuser:
  - An accepted s_sof sets pending_sof.
  - The next word pushed carries tuser=1, and pending_sof clears.
  - SOF and EOL on the same pixel are legal: a 1-pixel line.
- SOF with r!=0: discard the residual bytes (r=0 before processing the pixel) and set sync_err=1. sync_err stays set until reset.
- Reset (rst=0 at an edge), including mid-operation:
  - Clears: FIFO emptied, r=0, state=RUN, pending_sof=0, sync_err=0.
  - Outputs then read: m_axis_tvalid=0, tdata=0, tuser=0, tlast=0, s_ready=1.
  - Nothing from a partial word survives reset.
- A line length that is a multiple of 4 never enters FLUSH.

Decomposition:
- Shared package or common_defs: COLOR_WIDTH; the packed word struct {tdata[31:0], tuser, tlast}; a state enum {RUN, FLUSH}.
- Sub-module: axis_skid_fifo2, the generic 2-entry FIFO with a registered count. Reusable by other AXI-Stream stages.

Test Plan:
- Line of 4 pixels 0x10,0x20,0x30,0x40 (SOF on the first, EOL on the last), tready=1 -> words 0x20101010 (tuser=1), 0x30302020, 0x40404030 (tlast=1). No FLUSH, s_ready stays 1.
- 1-pixel line 0xAA with SOF+EOL -> a single word 0x00AAAAAA with tuser=1 and tlast=1. s_ready=0 for exactly one cycle (FLUSH).
- 2-pixel line 0x11,0x22 with EOL on 0x22 -> 0x22111111 (tlast=0), then 0x00002222 (tlast=1).
- 640-pixel line streamed continuously, tready toggling in a pattern that includes a 10-cycle low burst -> exactly 480 words, byte order intact, no loss or duplication. Check:
  - s_ready falls only when the FIFO holds 2 words.
  - tdata is stable while tvalid&&!tready.
- SOF on the 2nd pixel of a line (r=3) -> sync_err=1 and stays high. The next word has tuser=1 and contains only the new pixel's bytes.
- rst=0 for one cycle mid-line with 2 words queued -> cycle after: tvalid=0, s_ready=1, sync_err=0. The next SOF line packs from r=0.
